// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the two requester ports and the memory-side bus of mem_bus_arbiter.
//
// Signals (per requester N = 0/1):
//   reqN, lockN, weN, addrN, wdataN : requester -> arbiter
//   gntN, rvalidN                   : arbiter -> requester
//   rdata                           : arbiter -> both requesters (shared)
// Memory side:
//   mem_cs, mem_we, mem_addr, mem_wdata, mem_oe : arbiter -> memory / bus driver
//   mem_rdata                                   : memory bus -> arbiter
//
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and memory environment's view
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              lock0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              lock1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_oe;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata, mem_oe
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata, mem_oe
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-port memory between port 0 (CPU) and port 1
// (loader/DMA/init path) with a registered-grant req/gnt handshake and
// optional locked multi-cycle ownership.
//
// Ports:
//   CLK  : clock, all state updates on posedge
//   RST  : synchronous active-high reset
//   bus  : mem_bus_arbiter_if.slave (requester ports + memory bus)
//   grants0/grants1/conflicts/forced : 16-bit saturating statistics,
//          present only when MEM_BUS_ARB_STATS_EN is defined
//
// Parameters:
//   ADDR_W, DATA_W : memory geometry
//   RR_MODE        : 0 = fixed priority (port 0 wins ties), 1 = round-robin
//   MAX_HOLD       : owned cycles before a forced release while the other
//                    port is waiting (2..255)
//
// Optional feature macro: MEM_BUS_ARB_STATS_EN
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic             CLK,
  input  logic             RST,
  mem_bus_arbiter_if.slave bus
`ifdef MEM_BUS_ARB_STATS_EN
  ,
  output logic [15:0]      grants0,
  output logic [15:0]      grants1,
  output logic [15:0]      conflicts,
  output logic [15:0]      forced
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_hold;
  logic [7:0]        w_hold_next;
  logic              r_pref1;      // 1: port 1 wins the next tie (round-robin)
  logic              w_pref1_next;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata;

  logic              w_sel1;
  logic              w_own_req;
  logic              w_own_lock;
  logic              w_other_req;
  logic              w_access;
  logic              w_hold_full;
  logic              w_release;
  logic              w_forced;
  logic              w_conflict;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Owner-relative view of the request lines so the OWN0/OWN1 logic is shared.
  assign w_sel1      = (r_state == OWN1);
  assign w_own_req   = w_sel1 ? bus.req1  : bus.req0;
  assign w_own_lock  = w_sel1 ? bus.lock1 : bus.lock0;
  assign w_other_req = w_sel1 ? bus.req0  : bus.req1;
  assign w_sel_we    = w_sel1 ? bus.we1    : bus.we0;
  assign w_sel_addr  = w_sel1 ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_sel1 ? bus.wdata1 : bus.wdata0;

  // An access needs both ownership and a live request; a dropped request
  // while owning produces no memory cycle.
  assign w_access    = (r_state != IDLE) && w_own_req;
  assign w_hold_full = (r_hold == HOLD_LAST);
  assign w_release   = !w_own_req || !w_own_lock || (w_hold_full && w_other_req);
  // Forced only when the owner would otherwise have kept the bus.
  assign w_forced    = w_access && w_own_lock && w_hold_full && w_other_req;
  assign w_conflict  = (r_state == IDLE) && bus.req0 && bus.req1;

  always_comb begin
    w_next_state = r_state;
    w_hold_next  = r_hold;
    w_pref1_next = r_pref1;
    case (r_state)
      IDLE: begin
        w_hold_next = '0;
        if (bus.req0 && bus.req1) begin
          w_next_state = ((RR_MODE != 0) && r_pref1) ? OWN1 : OWN0;
        end else if (bus.req0) begin
          w_next_state = OWN0;
        end else if (bus.req1) begin
          w_next_state = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (w_release) begin
          w_hold_next  = '0;
          // The releasing port loses the next tie.
          w_pref1_next = !w_sel1;
          // Hand over directly when the other port is waiting: no IDLE bubble.
          if (w_other_req) begin
            w_next_state = w_sel1 ? OWN0 : OWN1;
          end else begin
            w_next_state = IDLE;
          end
        end else if (!w_hold_full) begin
          w_hold_next = r_hold + 8'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_pref1   <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_hold    <= w_hold_next;
      r_pref1   <= w_pref1_next;
      r_rvalid0 <= w_access && !w_sel1 && !w_sel_we;
      r_rvalid1 <= w_access &&  w_sel1 && !w_sel_we;
      // Memory presents read data at the negedge, so it is stable here.
      if (w_access && !w_sel_we) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.gnt0    = (r_state == OWN0);
  assign bus.gnt1    = (r_state == OWN1);
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata   = r_rdata;

  // Memory controls come straight from the owner; the non-owner is muted.
  assign bus.mem_cs    = w_access;
  assign bus.mem_we    = w_access && w_sel_we;
  assign bus.mem_oe    = w_access && w_sel_we;
  assign bus.mem_addr  = w_access ? w_sel_addr  : '0;
  assign bus.mem_wdata = w_access ? w_sel_wdata : '0;

`ifdef MEM_BUS_ARB_STATS_EN
  logic [15:0] r_grants0;
  logic [15:0] r_grants1;
  logic [15:0] r_conflicts;
  logic [15:0] r_forced;
  logic        w_edge0;
  logic        w_edge1;

  assign w_edge0 = (w_next_state == OWN0) && (r_state != OWN0);
  assign w_edge1 = (w_next_state == OWN1) && (r_state != OWN1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grants0   <= '0;
      r_grants1   <= '0;
      r_conflicts <= '0;
      r_forced    <= '0;
    end else begin
      if (w_edge0 && (r_grants0 != 16'hFFFF)) begin
        r_grants0 <= r_grants0 + 16'd1;
      end
      if (w_edge1 && (r_grants1 != 16'hFFFF)) begin
        r_grants1 <= r_grants1 + 16'd1;
      end
      if (w_conflict && (r_conflicts != 16'hFFFF)) begin
        r_conflicts <= r_conflicts + 16'd1;
      end
      if (w_forced && (r_forced != 16'hFFFF)) begin
        r_forced <= r_forced + 16'd1;
      end
    end
  end

  assign grants0   = r_grants0;
  assign grants1   = r_grants1;
  assign conflicts = r_conflicts;
  assign forced    = r_forced;
`else
  // Without statistics the tie/force detectors have no consumer.
  logic w_unused_stats;
  assign w_unused_stats = w_conflict ^ w_forced;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Two arbiters driven by identical requester stimulus:
//   instance 0: fixed priority, MAX_HOLD = 4
//   instance 1: round-robin,    MAX_HOLD = 8
// Each has its own behavioural memory device and its own reference model
// tracking "who owns the bus, for how long, who goes next".
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_f ();
  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_r ();

  logic          t_req   [2];
  logic          t_lock  [2];
  logic          t_we    [2];
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_wdata [2];

  assign bus_f.req0 = t_req[0];   assign bus_r.req0 = t_req[0];
  assign bus_f.lock0 = t_lock[0]; assign bus_r.lock0 = t_lock[0];
  assign bus_f.we0 = t_we[0];     assign bus_r.we0 = t_we[0];
  assign bus_f.addr0 = t_addr[0]; assign bus_r.addr0 = t_addr[0];
  assign bus_f.wdata0 = t_wdata[0]; assign bus_r.wdata0 = t_wdata[0];
  assign bus_f.req1 = t_req[1];   assign bus_r.req1 = t_req[1];
  assign bus_f.lock1 = t_lock[1]; assign bus_r.lock1 = t_lock[1];
  assign bus_f.we1 = t_we[1];     assign bus_r.we1 = t_we[1];
  assign bus_f.addr1 = t_addr[1]; assign bus_r.addr1 = t_addr[1];
  assign bus_f.wdata1 = t_wdata[1]; assign bus_r.wdata1 = t_wdata[1];

`ifdef MEM_BUS_ARB_STATS_EN
  logic [15:0] s_g0 [2];
  logic [15:0] s_g1 [2];
  logic [15:0] s_cf [2];
  logic [15:0] s_fr [2];
`endif

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_HOLD(4)) u_fix (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_f)
`ifdef MEM_BUS_ARB_STATS_EN
    , .grants0(s_g0[0]), .grants1(s_g1[0]), .conflicts(s_cf[0]), .forced(s_fr[0])
`endif
  );

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_HOLD(8)) u_rr (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_r)
`ifdef MEM_BUS_ARB_STATS_EN
    , .grants0(s_g0[1]), .grants1(s_g1[1]), .conflicts(s_cf[1]), .forced(s_fr[1])
`endif
  );

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 5) return 32'h00412022;
    return 32'hA5000000 ^ (i * 32'h00010203);
  endfunction

  // Behavioural memory devices: act on the negedge inside the access cycle.
  logic [DW-1:0] dev_mem [2][128];
  bit            dev_ready = 1'b0;
  always @(negedge CLK) begin
    if (!dev_ready) begin
      for (int i = 0; i < 128; i++) begin
        dev_mem[0][i] <= init_val(i);
        dev_mem[1][i] <= init_val(i);
      end
      dev_ready <= 1'b1;
    end else begin
      if (bus_f.mem_cs) begin
        if (bus_f.mem_we) dev_mem[0][bus_f.mem_addr] <= bus_f.mem_wdata;
        else              bus_f.mem_rdata <= dev_mem[0][bus_f.mem_addr];
      end
      if (bus_r.mem_cs) begin
        if (bus_r.mem_we) dev_mem[1][bus_r.mem_addr] <= bus_r.mem_wdata;
        else              bus_r.mem_rdata <= dev_mem[1][bus_r.mem_addr];
      end
    end
  end

  // Observation arrays so both instances are checked by one loop.
  logic [1:0]    o_gnt   [2];
  logic [1:0]    o_rv    [2];
  logic [DW-1:0] o_rdata [2];
  logic          o_cs    [2];
  logic          o_we    [2];
  logic          o_oe    [2];
  logic [AW-1:0] o_addr  [2];
  logic [DW-1:0] o_wd    [2];
  assign o_gnt[0] = {bus_f.gnt1, bus_f.gnt0};       assign o_gnt[1] = {bus_r.gnt1, bus_r.gnt0};
  assign o_rv[0]  = {bus_f.rvalid1, bus_f.rvalid0}; assign o_rv[1]  = {bus_r.rvalid1, bus_r.rvalid0};
  assign o_rdata[0] = bus_f.rdata;   assign o_rdata[1] = bus_r.rdata;
  assign o_cs[0]  = bus_f.mem_cs;    assign o_cs[1]  = bus_r.mem_cs;
  assign o_we[0]  = bus_f.mem_we;    assign o_we[1]  = bus_r.mem_we;
  assign o_oe[0]  = bus_f.mem_oe;    assign o_oe[1]  = bus_r.mem_oe;
  assign o_addr[0] = bus_f.mem_addr; assign o_addr[1] = bus_r.mem_addr;
  assign o_wd[0]  = bus_f.mem_wdata; assign o_wd[1]  = bus_r.mem_wdata;

  // Reference model state (owner = -1 means nobody owns the bus).
  int            m_own    [2];
  int            m_held   [2];
  int            m_next   [2];   // port that wins the next tie
  logic [1:0]    m_rv     [2];
  logic [DW-1:0] m_rdata  [2];
  logic [DW-1:0] ref_mem  [2][128];
  int            m_grants [2][2];
  int            m_conf   [2];
  int            m_forced [2];

  int tests = 0;
  int fails = 0;

  function automatic bit is_rr(int d);
    return d == 1;
  endfunction

  function automatic int max_hold(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[inst%0d]: observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset(int d);
    m_own[d] = -1; m_held[d] = 0; m_next[d] = 0;
    m_rv[d] = 2'b00; m_rdata[d] = '0;
    m_grants[d][0] = 0; m_grants[d][1] = 0; m_conf[d] = 0; m_forced[d] = 0;
  endtask

  function automatic int sat16(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // Memory bus expected during the current cycle.
  task automatic check_comb(int d);
    int o = m_own[d];
    bit acc = 1'b0;
    if (o >= 0) acc = t_req[o];
    chk("mem_cs", d, o_cs[d], acc);
    chk("mem_we", d, o_we[d], acc ? t_we[o] : 1'b0);
    chk("mem_oe", d, o_oe[d], acc ? t_we[o] : 1'b0);
    chk("mem_addr", d, o_addr[d], acc ? t_addr[o] : '0);
    chk("mem_wdata", d, o_wd[d], acc ? t_wdata[o] : '0);
  endtask

  // Apply the ownership rules for the clock edge ending the current cycle.
  task automatic model_advance(int d);
    int o = m_own[d];
    int oth;
    int nxt;
    bit acc = 1'b0;
    if (RST) begin
      model_reset(d);
      return;
    end
    if (o >= 0) acc = t_req[o];
    m_rv[d] = 2'b00;
    if (acc) begin
      if (t_we[o]) begin
        ref_mem[d][t_addr[o]] = t_wdata[o];
      end else begin
        m_rv[d][o] = 1'b1;
        m_rdata[d] = ref_mem[d][t_addr[o]];
      end
    end
    if (o < 0) begin
      nxt = -1;
      if (t_req[0] && t_req[1]) begin
        m_conf[d] = sat16(m_conf[d]);
        nxt = is_rr(d) ? m_next[d] : 0;
      end else if (t_req[0]) nxt = 0;
      else if (t_req[1]) nxt = 1;
      m_held[d] = 0;
    end else begin
      oth = 1 - o;
      if (t_req[o] && t_lock[o] && !(m_held[d] == max_hold(d) - 1 && t_req[oth])) begin
        nxt = o;
        if (m_held[d] < max_hold(d) - 1) m_held[d]++;
      end else begin
        if (t_req[o] && t_lock[o]) m_forced[d] = sat16(m_forced[d]);
        m_next[d] = oth;
        nxt = t_req[oth] ? oth : -1;
        m_held[d] = 0;
      end
    end
    if (nxt >= 0 && nxt != o) m_grants[d][nxt] = sat16(m_grants[d][nxt]);
    m_own[d] = nxt;
  endtask

  task automatic check_regs(int d);
    logic [1:0] eg;
    eg = 2'b00;
    if (m_own[d] >= 0) eg[m_own[d]] = 1'b1;
    chk("gnt", d, o_gnt[d], eg);
    chk("rvalid", d, o_rv[d], m_rv[d]);
    chk("rdata", d, o_rdata[d], m_rdata[d]);
`ifdef MEM_BUS_ARB_STATS_EN
    chk("grants0", d, s_g0[d], m_grants[d][0]);
    chk("grants1", d, s_g1[d], m_grants[d][1]);
    chk("conflicts", d, s_cf[d], m_conf[d]);
    chk("forced", d, s_fr[d], m_forced[d]);
`endif
  endtask

  // One clock cycle: inputs are already driven for this cycle.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_comb(d);
      model_advance(d);
    end
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) check_regs(d);
    $display("[TB] t=%0t rst=%0b req=%0b%0b lock=%0b%0b gnt_f=%b gnt_r=%b rv_f=%b rv_r=%b rdata_f=%h",
             $time, RST, t_req[1], t_req[0], t_lock[1], t_lock[0],
             o_gnt[0], o_gnt[1], o_rv[0], o_rv[1], o_rdata[0]);
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      t_req[p] = 1'b0; t_lock[p] = 1'b0; t_we[p] = 1'b0;
      t_addr[p] = '0; t_wdata[p] = '0;
    end
  endtask

  logic [DW-1:0] burst_val [4];
  int            n_gnt0;

  initial begin
    burst_val[0] = 32'h6; burst_val[1] = 32'h12; burst_val[2] = 32'h18; burst_val[3] = 32'hC;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      for (int i = 0; i < 128; i++) ref_mem[d][i] = init_val(i);
    end
    idle_inputs();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) step();
    RST = 1'b0;

    // First read: grant one cycle after request, rvalid one cycle after access.
    t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 7'h05;
    step();
    for (int d = 0; d < 2; d++) chk("first_gnt", d, o_gnt[d], 2'b01);
    step();
    for (int d = 0; d < 2; d++) begin
      chk("first_rvalid", d, o_rv[d], 2'b01);
      chk("first_rdata", d, o_rdata[d], 32'h00412022);
    end
    t_req[0] = 1'b0;
    step(); step();

    // Simultaneous requests, port 0 locked, then handoff without IDLE.
    t_req[0] = 1'b1; t_lock[0] = 1'b1; t_addr[0] = 7'h10;
    t_req[1] = 1'b1; t_lock[1] = 1'b0; t_addr[1] = 7'h11;
    step();
    chk("tie_fixed", 0, o_gnt[0], 2'b01);
    step();
    t_lock[0] = 1'b0;
    step();
    chk("handoff", 0, o_gnt[0], 2'b10);
    idle_inputs();
    step(); step();

    // Continuous unlocked requests: ownership alternates.
    t_req[0] = 1'b1; t_req[1] = 1'b1; t_addr[0] = 7'h05; t_addr[1] = 7'h06;
    for (int i = 0; i < 8; i++) step();
    idle_inputs();
    step(); step();

    // Port 1 locked write burst with port 0 also requesting a write.
    t_req[1] = 1'b1; t_lock[1] = 1'b1; t_we[1] = 1'b1;
    t_addr[1] = 7'd0; t_wdata[1] = burst_val[0];
    step();
    for (int k = 0; k < 4; k++) begin
      t_addr[1] = 7'(k); t_wdata[1] = burst_val[k]; t_lock[1] = (k != 3);
      t_req[0] = 1'b1; t_we[0] = 1'b1; t_addr[0] = 7'h7F; t_wdata[0] = 32'hDEADBEEF;
      step();
      if (k < 3) for (int d = 0; d < 2; d++) chk("burst_hold", d, o_gnt[d], 2'b10);
    end
    idle_inputs();
    step(); step();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) chk("burst_mem", d, dev_mem[d][k], burst_val[k]);

    // Forced release: both locked and requesting.
    t_req[0] = 1'b1; t_lock[0] = 1'b1; t_addr[0] = 7'h20;
    t_req[1] = 1'b1; t_lock[1] = 1'b1; t_addr[1] = 7'h21;
    n_gnt0 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_gnt[0] == 2'b01) n_gnt0++;
    end
    chk("forced_len", 0, n_gnt0, 4);
    chk("forced_next", 0, o_gnt[0], 2'b10);
    idle_inputs();
    step(); step();

    // Reset in the middle of a locked read.
    t_req[0] = 1'b1; t_lock[0] = 1'b1; t_addr[0] = 7'h05;
    step(); step();
    RST = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, o_gnt[d], 2'b00);
      chk("rst_rvalid", d, o_rv[d], 2'b00);
    end
    RST = 1'b0;
    step();
    idle_inputs();
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        t_req[p]   = ($urandom_range(0, 3) != 0);
        t_lock[p]  = $urandom_range(0, 1);
        t_we[p]    = $urandom_range(0, 1);
        t_addr[p]  = 7'($urandom_range(0, 31));
        t_wdata[p] = $urandom;
      end
      RST = ($urandom_range(0, 99) == 0);
      step();
    end
    RST = 1'b0;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
